// File: rtl/avl_mm_burst_ram.sv
// rtl/avl_mm_burst_ram.sv - Avalon-MM burst-capable RAM slave
// Fixed-latency read pipeline, optional wait states, out-of-range beat error reporting.
module avl_mm_burst_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avl_address,
  input  logic                  avl_write,
  input  logic                  avl_read,
  input  logic [11:0]           avl_burstcount,
  input  logic                  avl_beginbursttransfer,
  input  logic [DATA_WIDTH-1:0] avl_writedata,
  output logic [DATA_WIDTH-1:0] avl_readdata,
  output logic                  avl_readdatavalid,
  output logic                  avl_waitrequest_n,
  output logic [1:0]            avl_response,
  output logic [15:0]           err_count
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(BYTES);
  localparam int IDX_HI = DEPTH_LOG2 + OFF;
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(BYTES);
  localparam logic [4:0] WAIT_C   = 5'(WAIT_CYCLES);
  localparam logic       WRN_IDLE = 1'(WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, WR_BURST, RD_BURST} state_t;

  state_t                  r_state;
  logic                    r_wrn;
  logic [4:0]              r_wait_cnt;
  logic [11:0]             r_left;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [15:0]             r_err_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];
  logic                    r_vld [READ_LATENCY];
  logic                    r_err [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];

  logic                    w_cmd_phase;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_beat_addr;
  logic [DEPTH_LOG2-1:0]   w_beat_idx;
  logic                    w_beat_oor;
  logic                    w_wr_en;
  logic                    w_rd_issue;
  logic                    w_err_inc;
  logic [11:0]             w_bc;
  logic                    w_unused;

  // The acceptance cycle uses the bus address; burst beats use the latched running address.
  assign w_cmd_phase = (r_state == IDLE) || (r_state == WAIT);
  assign w_accept    = w_cmd_phase && r_wrn && (avl_write || avl_read);
  assign w_beat_addr = w_cmd_phase ? avl_address : r_addr;
  assign w_beat_idx  = w_beat_addr[IDX_HI-1:OFF];
  assign w_beat_oor  = (w_beat_addr >> IDX_HI) != '0;
  assign w_wr_en     = !reset && avl_write && (w_accept || (r_state == WR_BURST));
  assign w_rd_issue  = !reset && ((w_accept && !avl_write) || (r_state == RD_BURST));
  assign w_err_inc   = (w_wr_en || w_rd_issue) && w_beat_oor;
  assign w_bc        = (avl_burstcount == 12'd0) ? 12'd1 : avl_burstcount;
  assign w_unused    = &{1'b0, avl_beginbursttransfer, w_beat_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wrn      <= WRN_IDLE;
      r_wait_cnt <= '0;
      r_left     <= '0;
      r_addr     <= '0;
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          if (w_accept) begin
            r_addr     <= avl_address + BEAT_INC;
            r_left     <= w_bc - 12'd1;
            r_wait_cnt <= '0;
            if (w_bc == 12'd1) begin
              r_state <= IDLE;
              r_wrn   <= WRN_IDLE;
            end else if (avl_write) begin
              r_state <= WR_BURST;
              r_wrn   <= 1'b1;
            end else begin
              r_state <= RD_BURST;
              r_wrn   <= 1'b0;
            end
          end else if (r_state == IDLE) begin
            if (avl_write || avl_read) begin
              // The request's IDLE cycle is the first of the wait-state cycles.
              r_state    <= WAIT;
              r_wait_cnt <= 5'd1;
              r_wrn      <= (WAIT_C == 5'd1);
            end
          end else if (r_wrn) begin
            r_state <= IDLE;
            r_wrn   <= WRN_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 5'd1;
            r_wrn      <= ((r_wait_cnt + 5'd1) == WAIT_C);
          end
        end
        WR_BURST: begin
          if (avl_write) begin
            r_addr <= r_addr + BEAT_INC;
            r_left <= r_left - 12'd1;
            if (r_left == 12'd1) begin
              r_state <= IDLE;
              r_wrn   <= WRN_IDLE;
            end
          end
        end
        RD_BURST: begin
          r_addr <= r_addr + BEAT_INC;
          r_left <= r_left - 12'd1;
          if (r_left == 12'd1) begin
            r_state <= IDLE;
            r_wrn   <= WRN_IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_wrn   <= WRN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // Memory is deliberately left out of reset so contents survive an aborted burst.
  always_ff @(posedge clk) begin
    if (w_wr_en && !w_beat_oor) begin
      r_mem[w_beat_idx] <= avl_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_rd_issue;
      r_err[0] <= w_rd_issue && w_beat_oor;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_dat[0] <= w_beat_oor ? '0 : r_mem[w_beat_idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_dat[i] <= r_dat[i-1];
    end
  end

  assign avl_readdatavalid = r_vld[READ_LATENCY-1];
  assign avl_readdata      = r_vld[READ_LATENCY-1] ? r_dat[READ_LATENCY-1] : '0;
  assign avl_response      = (r_vld[READ_LATENCY-1] && r_err[READ_LATENCY-1]) ? 2'b10 : 2'b00;
  assign avl_waitrequest_n = r_wrn;
  assign err_count         = r_err_cnt;

endmodule

// File: tb/tb_avl_mm_burst_ram.sv
// tb/tb_avl_mm_burst_ram.sv - self-checking bench for avl_mm_burst_ram
module tb_avl_mm_burst_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] avl_address = '0;
  logic        avl_write = 1'b0;
  logic        avl_read = 1'b0;
  logic [11:0] avl_burstcount = '0;
  logic        avl_beginbursttransfer = 1'b0;
  logic [31:0] avl_writedata = '0;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic        avl_waitrequest_n;
  logic [1:0]  avl_response;
  logic [15:0] err_count;

  logic [31:0] d3_address = '0;
  logic        d3_write = 1'b0;
  logic        d3_read = 1'b0;
  logic [11:0] d3_burstcount = '0;
  logic        d3_bbt = 1'b0;
  logic [31:0] d3_writedata = '0;
  logic [31:0] d3_readdata;
  logic        d3_rdv;
  logic        d3_wrn;
  logic [1:0]  d3_resp;
  logic [15:0] d3_err;

  avl_mm_burst_ram dut (
    .clk(clk), .reset(reset), .avl_address(avl_address), .avl_write(avl_write),
    .avl_read(avl_read), .avl_burstcount(avl_burstcount),
    .avl_beginbursttransfer(avl_beginbursttransfer), .avl_writedata(avl_writedata),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_response(avl_response),
    .err_count(err_count)
  );

  avl_mm_burst_ram #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .avl_address(d3_address), .avl_write(d3_write),
    .avl_read(d3_read), .avl_burstcount(d3_burstcount),
    .avl_beginbursttransfer(d3_bbt), .avl_writedata(d3_writedata),
    .avl_readdata(d3_readdata), .avl_readdatavalid(d3_rdv),
    .avl_waitrequest_n(d3_wrn), .avl_response(d3_resp), .err_count(d3_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;       // 0 write, 1 read, 2 write+read together
    logic [31:0] addr;
    int          bc;
    logic [31:0] data;     // write base data, or expected read base data
    logic [15:0] exp_err;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        expq[$];
  logic [31:0] mem_m [1024];
  int          err_m = 0;
  vec_t        vecs [12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Read-return monitor: every cycle the valid flag must match the expected schedule.
  always @(negedge clk) begin : monitor
    logic exp_v;
    exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
    chk("rdv", 32'(avl_readdatavalid), 32'(exp_v));
    if (exp_v && avl_readdatavalid) begin
      chk("rd_data", avl_readdata, expq[0].data);
      chk("rd_resp", 32'(avl_response), 32'(expq[0].resp));
    end else if (!avl_readdatavalid) begin
      chk("idle_data", avl_readdata, 32'h0);
      chk("idle_resp", 32'(avl_response), 32'h0);
    end
    if (exp_v || ((expq.size() > 0) && (expq[0].cyc < cyc))) void'(expq.pop_front());
  end

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    if (a >= 32'd4096) err_m++;
    else mem_m[a[11:2]] = d;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int bc, input logic [31:0] base,
                          input bit rnd, input bit with_rd);
    int n;
    int k;
    logic [31:0] d;
    n = (bc == 0) ? 1 : bc;
    d = rnd ? $urandom : base;
    avl_address = addr; avl_burstcount = 12'(bc); avl_write = 1'b1; avl_read = with_rd;
    avl_beginbursttransfer = 1'b1; avl_writedata = d;
    chk("wr_accept_wrn", 32'(avl_waitrequest_n), 32'h1);
    model_wr(addr, d);
    k = 1;
    @(negedge clk);
    avl_read = 1'b0; avl_beginbursttransfer = 1'b0; avl_write = 1'b0;
    while (k < n) begin
      chk("wr_burst_wrn", 32'(avl_waitrequest_n), 32'h1);
      if (rnd && ($urandom_range(0, 3) == 0)) begin
        avl_write = 1'b0;
      end else begin
        d = rnd ? $urandom : base + 32'(k);
        avl_write = 1'b1; avl_writedata = d;
        model_wr(addr + 32'(4 * k), d);
        k++;
      end
      @(negedge clk);
      avl_write = 1'b0;
    end
    chk("wr_err", 32'(err_count), 32'(err_m));
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int bc, input bit use_tbl,
                          input logic [31:0] exp_base);
    int n;
    logic [31:0] a;
    exp_t e;
    n = (bc == 0) ? 1 : bc;
    avl_address = addr; avl_burstcount = 12'(bc); avl_read = 1'b1; avl_beginbursttransfer = 1'b1;
    chk("rd_accept_wrn", 32'(avl_waitrequest_n), 32'h1);
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(4 * k);
      e.cyc = cyc + 2 + k;
      if (a >= 32'd4096) begin
        e.data = '0; e.resp = 2'b10; err_m++;
      end else begin
        e.data = use_tbl ? exp_base + 32'(k) : mem_m[a[11:2]]; e.resp = 2'b00;
      end
      expq.push_back(e);
    end
    @(negedge clk);
    avl_read = 1'b0; avl_beginbursttransfer = 1'b0;
    for (int k = 1; k < n; k++) begin
      chk("rd_burst_wrn", 32'(avl_waitrequest_n), 32'h0);
      @(negedge clk);
    end
    chk("rd_done_wrn", 32'(avl_waitrequest_n), 32'h1);
    chk("rd_err", 32'(err_count), 32'(err_m));
  endtask

  initial begin
    vecs[0]  = '{0, 32'h0000_000A, 1, 32'h0000_AAAA, 16'd0};
    vecs[1]  = '{1, 32'h0000_000A, 1, 32'h0000_AAAA, 16'd0};
    vecs[2]  = '{0, 32'h0000_0010, 4, 32'h0000_0001, 16'd0};
    vecs[3]  = '{1, 32'h0000_0010, 4, 32'h0000_0001, 16'd0};
    vecs[4]  = '{0, 32'h0000_0FF8, 2, 32'h0000_0055, 16'd0};
    vecs[5]  = '{1, 32'h0000_0FFC, 2, 32'h0000_0056, 16'd1};
    vecs[6]  = '{0, 32'h0000_1000, 1, 32'h0000_DEAD, 16'd2};
    vecs[7]  = '{2, 32'h0000_0020, 1, 32'h0000_0077, 16'd2};
    vecs[8]  = '{1, 32'h0000_0020, 1, 32'h0000_0077, 16'd2};
    vecs[9]  = '{0, 32'h0000_0030, 0, 32'h0000_0099, 16'd2};
    vecs[10] = '{1, 32'h0000_0030, 0, 32'h0000_0099, 16'd2};
    vecs[11] = '{1, 32'h0000_0013, 1, 32'h0000_0001, 16'd2};

    repeat (3) @(negedge clk);
    chk("rst_rdv", 32'(avl_readdatavalid), 32'h0);
    chk("rst_data", avl_readdata, 32'h0);
    chk("rst_resp", 32'(avl_response), 32'h0);
    chk("rst_wrn", 32'(avl_waitrequest_n), 32'h1);
    chk("rst_err", 32'(err_count), 32'h0);
    chk("rst_wrn_w3", 32'(d3_wrn), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    wr_burst(32'h0, 1024, 32'h0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].op == 1) rd_burst(vecs[i].addr, vecs[i].bc, 1'b1, vecs[i].data);
      else wr_burst(vecs[i].addr, vecs[i].bc, vecs[i].data, 1'b0, vecs[i].op == 2);
      chk("tbl_err", 32'(err_count), 32'(vecs[i].exp_err));
    end

    // Reset during the second beat of a 4-beat read, then confirm memory survived.
    wr_burst(32'h40, 4, 32'h100, 1'b0, 1'b0);
    avl_address = 32'h40; avl_burstcount = 12'd4; avl_read = 1'b1;
    chk("abort_acc_wrn", 32'(avl_waitrequest_n), 32'h1);
    @(negedge clk);
    avl_read = 1'b0; reset = 1'b1;
    expq.delete();
    @(negedge clk);
    reset = 1'b0; err_m = 0;
    chk("abort_wrn", 32'(avl_waitrequest_n), 32'h1);
    chk("abort_err", 32'(err_count), 32'h0);
    repeat (4) @(negedge clk);
    rd_burst(32'h40, 4, 1'b1, 32'h100);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 1030) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) wr_burst(a, $urandom_range(0, 6), 32'h0, 1'b1, 1'b0);
      else rd_burst(a, $urandom_range(0, 6), 1'b0, 32'h0);
    end

    // Wait states on the WAIT_CYCLES=3 instance.
    d3_address = 32'h8; d3_burstcount = 12'd1; d3_write = 1'b1; d3_writedata = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      chk("w3_wr_wrn", 32'(d3_wrn), (i < 3) ? 32'h0 : 32'h1);
      @(negedge clk);
    end
    d3_write = 1'b0; d3_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("w3_rd_wrn", 32'(d3_wrn), (i < 3) ? 32'h0 : 32'h1);
      chk("w3_rdv_early", 32'(d3_rdv), 32'h0);
      @(negedge clk);
    end
    d3_read = 1'b0;
    chk("w3_rdv_lat1", 32'(d3_rdv), 32'h0);
    @(negedge clk);
    chk("w3_rdv", 32'(d3_rdv), 32'h1);
    chk("w3_data", d3_readdata, 32'h1234);
    chk("w3_resp", 32'(d3_resp), 32'h0);
    chk("w3_idle_wrn", 32'(d3_wrn), 32'h0);
    @(negedge clk);
    chk("w3_rdv_after", 32'(d3_rdv), 32'h0);

    repeat (10) @(negedge clk);
    chk("drain_empty", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_mm_burst_ram.md
AVL_MM_BURST_RAM -- requirements
Module: avl_mm_burst_ram

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, Avalon data width in bits (multiple of 8).
- REQ-002 SHALL have parameter ADDR_WIDTH, default 32, Avalon byte-address width.
- REQ-003 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in words.
- REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from beat issue to readdatavalid (range 1..8).
- REQ-005 SHALL have parameter WAIT_CYCLES, default 0, wait states inserted before accepting each command (range 0..15).
- REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
- REQ-007 clk  input  1  clock; all logic on rising edge.
- REQ-008 reset  input  1  synchronous active-high reset.
- REQ-009 avl_address  input  ADDR_WIDTH  byte address of first beat.
- REQ-010 avl_write  input  1  write request or write beat.
- REQ-011 avl_read  input  1  read request.
- REQ-012 avl_burstcount  input  12  beats in burst.
- REQ-013 avl_beginbursttransfer  input  1  first-cycle burst marker; ignored by logic.
- REQ-014 avl_writedata  input  DATA_WIDTH  write beat data.
- REQ-015 avl_readdata  output  DATA_WIDTH  read beat data.
- REQ-016 avl_readdatavalid  output  1  avl_readdata/avl_response valid.
- REQ-017 avl_waitrequest_n  output  1  high = command or write beat accepted this cycle.
- REQ-018 avl_response  output  2  00 OKAY, 10 SLAVEERROR; valid with readdatavalid.
- REQ-019 err_count  output  16  saturating count of out-of-range beats.

Function
- REQ-020 Word index SHALL be avl_address[DEPTH_LOG2+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
- REQ-021 Beat SHALL be out-of-range when its byte address >= (2^DEPTH_LOG2)*(DATA_WIDTH/8).
- REQ-022 FSM states SHALL be IDLE, WAIT, WR_BURST, RD_BURST.
- REQ-023 IDLE, read or write high: WAIT_CYCLES=0 -> accept same cycle (waitrequest_n=1); else go to WAIT, waitrequest_n=0.
- REQ-024 WAIT SHALL hold waitrequest_n=0 for WAIT_CYCLES cycles counted from the command's first cycle, then drive waitrequest_n=1 for one cycle and accept.
- REQ-025 Acceptance SHALL latch address and burstcount; burstcount 0 SHALL be treated as 1.
- REQ-026 Read and write both high at acceptance: write SHALL win; read ignored.
- REQ-027 Accepted write: first beat written on acceptance; if burstcount>1 go to WR_BURST, else IDLE.
- REQ-028 WR_BURST SHALL drive waitrequest_n=1, write one beat per cycle with avl_write high, hold on avl_write low, and return to IDLE after the last beat.
- REQ-029 Accepted read: go to RD_BURST, waitrequest_n=0, and issue one beat per cycle into a READ_LATENCY-deep pipeline, starting the acceptance cycle.
- REQ-030 RD_BURST SHALL return to IDLE the cycle after the last beat is issued; pipeline drains independently; new command may be accepted during drain.
- REQ-031 Read beat SHALL appear exactly READ_LATENCY cycles after issue, in order, one per cycle, gap-free within a burst.
- REQ-032 Beat address SHALL increment by DATA_WIDTH/8 per beat; no wrap.
- REQ-033 Out-of-range write beat SHALL be dropped; out-of-range read beat SHALL return readdata 0, response 10.
- REQ-034 err_count SHALL increment per out-of-range beat and saturate at 16'hFFFF.
- REQ-035 avl_readdata SHALL be 0 and avl_response 00 whenever avl_readdatavalid=0.

Reset
- REQ-036 Reset SHALL force IDLE, clear pipeline, beat/wait counters and err_count; outputs: readdatavalid=0, readdata=0, response=00, waitrequest_n=1 (WAIT_CYCLES=0) or 0 (otherwise).
- REQ-037 Reset mid-burst SHALL abort; no readdatavalid in the cycle after reset is sampled; memory contents SHALL NOT be cleared.

Verification
- REQ-038 Single write 0xAAAA to 0xA, then single read 0xA -> readdatavalid exactly 2 cycles after read acceptance, readdata 0xAAAA, response 00.
- REQ-039 Write burst of 4 at 0x10 (1,2,3,4), read burst of 4 -> 4 consecutive valid beats 1,2,3,4; waitrequest_n low for 3 cycles after read acceptance.
- REQ-040 WAIT_CYCLES=3, single read -> waitrequest_n low 3 cycles, high 1 cycle, data 2 cycles later.
- REQ-041 Read burst of 2 at byte address 4092 (DEPTH_LOG2=10) -> beat 1 OKAY, beat 2 readdata 0, response 10, err_count 1.
- REQ-042 Reset asserted during beat 2 of a 4-beat read -> no further readdatavalid; subsequent read returns previously written data.
- REQ-043 Read and write high together in IDLE -> write performed, no readdatavalid produced.
